load_store_unit: RTL and testbench

Memory-stage load/store sequencer for the 5-stage MIPS pipeline, acting as the initiator toward `data_memory`. It takes one load or store per request from the MEM stage and drives the word-addressed memory port. It performs sub-word extraction with sign/zero extension for loads, and read-modify-write for byte/halfword stores. While a request is in flight it stalls the pipeline.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store sequencer driving a word-addressed
// data memory. Loads extract and sign/zero-extend bytes and halfwords.
// Byte and halfword stores use a read-modify-write of the containing word.
// The unit stalls the pipeline while a request is in flight.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned requests go to ERR and pulse misalign.
//   undefined : low address bits are masked, size 11 acts as word, and
//               misalign is tied 0.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/write/size/signed  request from MEM stage (held until stall=0)
//   req_addr, req_wdata          byte address, right-justified store data
//   stall                        freeze the pipeline
//   load_valid, load_data        extended load result (0 when not valid)
//   misalign                     one-cycle pulse, request dropped
//   mem_access_addr              word index to memory
//   mem_write_data, mem_write_en full-word write toward memory
//   mem_read, mem_read_data      read enable and combinational read word
module load_store_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned XLEN = 32;

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        ERR    = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   merge_q, merge_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;

    logic              req_mis;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   merged;

    // Misalignment check on the incoming request
`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign misalign = (state_q == ERR);
`else
    assign req_mis  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Lane extraction and extension of the returned word for loads
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_read_data[7:0];
            2'd1:    rd_byte = mem_read_data[15:8];
            2'd2:    rd_byte = mem_read_data[23:16];
            default: rd_byte = mem_read_data[31:24];
        endcase
        rd_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Replace the addressed lane(s) of the captured word with store data
    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state, latched request fields and state-decoded outputs
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        merge_d         = merge_q;
        size_d          = size_q;
        signed_d        = signed_q;
        stall           = 1'b0;
        load_valid      = 1'b0;
        load_data       = '0;
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_write_data  = '0;
        mem_access_addr = {2'b00, addr_q[31:2]};

        case (state_q)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_mis)             state_d = ERR;
                    else
`endif
                    if (!req_write)          state_d = LOAD;
                    else if (req_size[1])    state_d = STORE;
                    else                     state_d = RMW_RD;
                end
            end
            LOAD: begin
                mem_read   = 1'b1;
                load_valid = 1'b1;
                load_data  = load_ext;
            end
            STORE: begin
                mem_write_en   = 1'b1;
                mem_write_data = wdata_q;
            end
            RMW_RD: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                merge_d  = mem_read_data;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_write_en   = 1'b1;
                mem_write_data = merged;
            end
            default: ;
        endcase

        // Completion cycles return to IDLE with the latched fields cleared
        if ((state_q != IDLE) && (state_q != RMW_RD)) begin
            state_d  = IDLE;
            addr_d   = '0;
            wdata_d  = '0;
            merge_d  = '0;
            size_d   = 2'b00;
            signed_d = 1'b0;
        end
    end

    // State and request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            size_q   <= size_d;
            signed_q <= signed_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 64-word memory (ram[i]=i at start), a
// directed vector table, reset sequences and randomized requests checked
// against an arithmetic reference model of the memory contents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, misalign, mem_write_en, mem_read;
    logic [31:0] load_data, mem_access_addr, mem_write_data, mem_read_data;

    logic [31:0] ram [64];
    logic [31:0] ref_ram [64];
    logic        mem_init;
    int          wr_edges;
    int          n_tests = 0;
    int          n_fail  = 0;

    load_store_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .stall           (stall),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .misalign        (misalign),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge
    assign mem_read_data = ram[mem_access_addr[5:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'(i);
            wr_edges <= 0;
        end else if (mem_write_en) begin
            ram[mem_access_addr[5:0]] <= mem_write_data;
            wr_edges <= wr_edges + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] ad);
`ifdef LSU_MISALIGN_TRAP_EN
        return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] ad);
        logic [31:0] w, v;
        w = ref_ram[(ad / 4) % 64];
        if (sz == 2'd0) begin
            v = (w >> (8 * (ad % 4))) & 32'hFF;
            if (sg && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * ((ad / 2) % 2))) & 32'hFFFF;
            if (sg && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        int idx, off;
        idx = (ad / 4) % 64;
        if (sz == 2'd0) begin
            off = 8 * (ad % 4);
            ref_ram[idx] = (ref_ram[idx] & ~(32'hFF << off)) | ((wd & 32'hFF) << off);
        end else if (sz == 2'd1) begin
            off = 16 * ((ad / 2) % 2);
            ref_ram[idx] = (ref_ram[idx] & ~(32'hFFFF << off)) | ((wd & 32'hFFFF) << off);
        end else begin
            ref_ram[idx] = wd;
        end
    endtask

    // Cycles from acceptance to completion, memory reads and writes expected
    function automatic int exp_len(input logic wr, input logic [1:0] sz, input logic m);
        return (!m && wr && sz < 2) ? 3 : 2;
    endfunction
    function automatic int exp_rd(input logic wr, input logic [1:0] sz, input logic m);
        return (!m && (!wr || sz < 2)) ? 1 : 0;
    endfunction
    function automatic int exp_wr(input logic wr, input logic m);
        return (!m && wr) ? 1 : 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Starts at a falling edge; returns at the falling edge after completion
    // with req_valid still high so a following request can be back-to-back.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output int len, output int nrd, output int nwr,
                          output int nlv, output logic [31:0] ld, output logic mis);
        logic done;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        len = 0; nrd = 0; nwr = 0; nlv = 0; ld = '0; mis = 1'b0; done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done) break;
            #2;
            chk("rd_wr_exclusive", 32'(mem_read & mem_write_en), 32'd0);
            if (mem_read)     nrd++;
            if (mem_write_en) nwr++;
            if (misalign)     mis = 1'b1;
            if (load_valid) begin
                nlv++;
                ld = load_data;
            end else begin
                chk("load_data_idle_zero", load_data, 32'd0);
            end
            len++;
            if (!stall) done = 1'b1;
            @(negedge clk);
        end
        if (!done) chk("completion_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 0; c < n; c++) begin
            #2;
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_addr", mem_access_addr, 32'd0);
            chk("idle_wdata", mem_write_data, 32'd0);
            chk("idle_mem_en", {30'd0, mem_read, mem_write_en}, 32'd0);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp;   // load result, or stored word for stores
        logic        mis;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int len, nrd, nwr, nlv, w0;
        logic [31:0] ld, eld;
        logic mis, m;
        logic wr, sg;
        logic [1:0] sz;
        logic [31:0] ad, wd;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h123456A5, 32'hDEADA5EF, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h9, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h9, 32'h0,        32'h000000A5, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'hE, 32'h8001,     32'h80010003, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'hE, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'hC, 32'h0,        32'h00000003, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0,        32'h00000000, 1'b1};
`else
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0,        32'h00000001, 1'b0};
`endif
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h55,       32'h00000055, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'h00000055, 1'b0};

        for (int i = 0; i < 64; i++) ref_ram[i] = 32'(i);

        // Reset: outputs quiet, stall follows req_valid
        reset_n = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_stall_low", 32'(stall), 32'd0);
        chk("rst_outputs", {28'd0, load_valid, misalign, mem_read, mem_write_en}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_addr", mem_access_addr, 32'd0);
        req_valid = 1'b1;
        #1 chk("rst_stall_follows", 32'(stall), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        mem_init = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        // Directed table, all requests back-to-back
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                   len, nrd, nwr, nlv, ld, mis);
            chk($sformatf("vec%0d_len", i), 32'(len), 32'(exp_len(vecs[i].wr, vecs[i].sz, vecs[i].mis)));
            chk($sformatf("vec%0d_misalign", i), 32'(mis), 32'(vecs[i].mis));
            chk($sformatf("vec%0d_reads", i), 32'(nrd), 32'(exp_rd(vecs[i].wr, vecs[i].sz, vecs[i].mis)));
            chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(exp_wr(vecs[i].wr, vecs[i].mis)));
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_mem_word", i), ram[vecs[i].ad[7:2]], vecs[i].exp);
                ref_store(vecs[i].sz, vecs[i].ad, vecs[i].wd);
            end else begin
                chk($sformatf("vec%0d_load_valid", i), 32'(nlv), vecs[i].mis ? 32'd0 : 32'd1);
                chk($sformatf("vec%0d_load_data", i), ld, vecs[i].exp);
            end
        end
        idle_cycles(2);

        // Reset during RMW_RD of sb 0x10: no write, word 4 untouched
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hFF;
        #2 chk("rmw_accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #2;
        chk("rmw_rd_stall", 32'(stall), 32'd1);
        chk("rmw_rd_read", 32'(mem_read), 32'd1);
        w0 = wr_edges;
        reset_n = 1'b0;
        #1;
        chk("midrst_no_mem", {30'd0, mem_read, mem_write_en}, 32'd0);
        chk("midrst_stall_follows", 32'(stall), 32'd1);
        req_valid = 1'b0;
        #1 chk("midrst_stall_low", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_no_write", 32'(wr_edges), 32'(w0));
        chk("midrst_word4", ram[4], 32'h00000004);
        chk("midrst_outputs", {28'd0, load_valid, misalign, mem_read, mem_write_en}, 32'd0);
        chk("midrst_addr", mem_access_addr, 32'd0);
        chk("midrst_wdata", mem_write_data, 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, len, nrd, nwr, nlv, ld, mis);
        chk("midrst_reload", ld, 32'h00000004);

        // Randomized requests against the reference model
        for (int n = 0; n < 200; n++) begin
            wr = 1'(($urandom) & 1);
            sg = 1'(($urandom) & 1);
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 255));
            wd = $urandom;
            m   = is_mis(sz, ad);
            eld = ref_load(sz, sg, ad);
            do_req(wr, sz, sg, ad, wd, len, nrd, nwr, nlv, ld, mis);
            chk("rnd_len", 32'(len), 32'(exp_len(wr, sz, m)));
            chk("rnd_misalign", 32'(mis), 32'(m));
            chk("rnd_reads", 32'(nrd), 32'(exp_rd(wr, sz, m)));
            chk("rnd_writes", 32'(nwr), 32'(exp_wr(wr, m)));
            if (wr && !m) ref_store(sz, ad, wd);
            if (!wr) begin
                chk("rnd_load_valid", 32'(nlv), m ? 32'd0 : 32'd1);
                chk("rnd_load_data", ld, m ? 32'd0 : eld);
            end
            chk("rnd_mem_word", ram[ad[7:2]], ref_ram[ad[7:2]]);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
